// File: rtl/msrv32_lsu_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: FSM states, access size codes
// and the load-result extension helper.
package msrv32_lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Size code 2'b11 falls through to the full word.
  function automatic logic [31:0] extend_f(input logic [31:0] v,
                                           input logic [1:0]  sz,
                                           input logic        uns);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      SZ_H:    r = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/msrv32_lsu_fmt.sv
// Combinational lane logic: store byte strobes / data replication and
// load lane selection with sign or zero extension.
module msrv32_lsu_fmt
  import msrv32_lsu_ctrl_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift_s;

  // Store strobes follow the low address bits; data is replicated on every lane.
  always_comb begin
    st_mask  = 4'b0000;
    st_wdata = 32'd0;
    case (st_size)
      SZ_B: begin
        st_mask  = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_mask  = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  always_comb begin
    ld_shift_s = ld_word >> {ld_addr_lo, 3'b000};
    ld_data    = extend_f(ld_shift_s, ld_size, ld_unsigned);
  end

endmodule

// File: rtl/msrv32_lsu_ctrl.sv
// Load/store sequencer: launches one data-memory access at a time, stalls the
// core until it completes or times out, and formats the returned load data.
module msrv32_lsu_ctrl
  import msrv32_lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        is_load_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        misaligned_load_in,
  input  logic        trap_taken_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wr_data_out,
  output logic [3:0]  dmem_wr_mask_out,
  input  logic        dmem_ready_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rd_data_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_data_valid_out,
  output logic        access_fault_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_r, next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             launch_s, stall_s, timeout_s;
  logic             req_r, we_r, unsigned_r, valid_r, fault_r;
  logic [1:0]       size_r, addr_lo_r;
  logic [31:0]      addr_r, wdata_r, load_data_r;
  logic [3:0]       mask_r;
  logic [3:0]       st_mask_s;
  logic [31:0]      st_wdata_s, ld_data_s;

  // Gating with rst_in keeps stall low while reset is held, even with a launch pending.
  assign launch_s = rst_in & (mem_wr_req_in |
                              (is_load_in & ~misaligned_load_in & ~trap_taken_in));

  msrv32_lsu_fmt u_fmt (
    .st_addr_lo  (addr_in[1:0]),
    .st_size     (load_size_in),
    .st_data     (store_data_in),
    .ld_addr_lo  (addr_lo_r),
    .ld_size     (size_r),
    .ld_unsigned (unsigned_r),
    .ld_word     (dmem_rd_data_in),
    .st_mask     (st_mask_s),
    .st_wdata    (st_wdata_s),
    .ld_data     (ld_data_s)
  );

  // Next-state, stall and timeout decode; a handshake in the last allowed cycle beats the timeout.
  always_comb begin
    next_s    = state_r;
    stall_s   = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s = launch_s;
        if (launch_s) next_s = REQ;
        else          next_s = IDLE;
      end
      REQ: begin
        stall_s = 1'b1;
        if (dmem_ready_in) begin
          if (we_r) next_s = DONE;
          else      next_s = WAIT_RD;
        end else if (cnt_r == CNT_LAST) begin
          next_s    = IDLE;
          timeout_s = 1'b1;
        end else begin
          next_s = REQ;
        end
      end
      WAIT_RD: begin
        stall_s = 1'b1;
        if (dmem_rvalid_in) begin
          next_s = DONE;
        end else if (cnt_r == CNT_LAST) begin
          next_s    = IDLE;
          timeout_s = 1'b1;
        end else begin
          next_s = WAIT_RD;
        end
      end
      DONE: begin
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State register and dwell counter, cleared whenever the state changes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= next_s;
      if (next_s != state_r)                      cnt_r <= '0;
      else if (state_r == REQ || state_r == WAIT_RD) cnt_r <= cnt_r + CNT_W'(1);
      else                                        cnt_r <= '0;
    end
  end

  // Access capture at launch, bus request flag, load result and status pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_r      <= 32'd0;
      addr_lo_r   <= 2'b00;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      we_r        <= 1'b0;
      mask_r      <= 4'b0000;
      wdata_r     <= 32'd0;
      req_r       <= 1'b0;
      valid_r     <= 1'b0;
      fault_r     <= 1'b0;
      load_data_r <= 32'd0;
    end else begin
      if (state_r == IDLE && launch_s) begin
        addr_r     <= {addr_in[31:2], 2'b00};
        addr_lo_r  <= addr_in[1:0];
        size_r     <= load_size_in;
        unsigned_r <= load_unsigned_in;
        we_r       <= mem_wr_req_in;
        mask_r     <= mem_wr_req_in ? st_mask_s  : 4'b0000;
        wdata_r    <= mem_wr_req_in ? st_wdata_s : 32'd0;
      end
      req_r   <= (next_s == REQ);
      valid_r <= (state_r == WAIT_RD) && dmem_rvalid_in;
      fault_r <= timeout_s;
      if (state_r == WAIT_RD && dmem_rvalid_in) load_data_r <= ld_data_s;
    end
  end

  assign dmem_req_out        = req_r;
  assign dmem_we_out         = we_r;
  assign dmem_addr_out       = addr_r;
  assign dmem_wr_data_out    = wdata_r;
  assign dmem_wr_mask_out    = mask_r;
  assign stall_out           = stall_s;
  assign load_data_out       = load_data_r;
  assign load_data_valid_out = valid_r;
  assign access_fault_out    = fault_r;

endmodule
